// File: rtl/yas_packet_tx_pkg.sv
// Shared definitions for the yas packet transmitter and its CRC helper:
// byte/length widths, CRC polynomial, header layout and FSM state encoding.
package yas_packet_tx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DATA_SIZE  = 6;
  localparam int ADDR_W     = 2;
  localparam logic [DATA_WIDTH-1:0] CRC_POLY = 8'h07;

  // Header layout: address in the low bits, length-minus-one above it.
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB  = ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACKLO = 2'd2,
    ST_FETCH = 2'd3
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [DATA_SIZE-1:0] len_m1,
    input logic [ADDR_W-1:0]    addr
  );
    logic [DATA_WIDTH-1:0] h;
    h = '0;
    h[HDR_LEN_LSB +: DATA_SIZE] = len_m1;
    h[HDR_ADDR_LSB +: ADDR_W]   = addr;
    return h;
  endfunction

endpackage

// File: rtl/yas_crc8.sv
// Combinational CRC-8 byte step (init/reflection/final XOR handled by caller:
// MSB-first, no reflection). Shared with the router's input checker.
module yas_crc8
  import yas_packet_tx_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] crc_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  output logic [DATA_WIDTH-1:0] crc_o
);

  always_comb begin
    logic [DATA_WIDTH-1:0] c;
    c = crc_i ^ byte_i;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c[DATA_WIDTH-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/yas_packet_tx.sv
// Packet transmitter: serialises header, payload and optional CRC-8 trailer
// onto the router's 4-phase req/ack byte interface.
module yas_packet_tx
  import yas_packet_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_SIZE-1:0]  cmd_len_m1,
  input  logic                  cmd_crc_en,
  input  logic [DATA_WIDTH-1:0] pl_data,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DATA_SIZE:0] CNT_ONE = {{DATA_SIZE{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] crc_q, crc_d, crc_next;
  logic [DATA_SIZE-1:0]  len_q, len_d;
  logic [DATA_SIZE:0]    cnt_q, cnt_d;
  logic                  tx_req_q, tx_req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  crc_en_q, crc_en_d;
  logic                  trl_q, trl_d;
  logic                  pl_last;

  yas_crc8 u_crc8 (
    .crc_i  (crc_q),
    .byte_i (tx_data_q),
    .crc_o  (crc_next)
  );

  // Counter is one bit wider than the length field so a 2**DATA_SIZE byte
  // payload terminates without wrapping.
  assign pl_last = (cnt_q == ({1'b0, len_q} + CNT_ONE));

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    crc_d     = crc_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tx_req_d  = tx_req_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    crc_en_d  = crc_en_q;
    trl_d     = trl_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d     = cmd_len_m1;
          crc_en_d  = cmd_crc_en;
          tx_data_d = make_header(cmd_len_m1, cmd_addr);
          crc_d     = '0;
          cnt_d     = '0;
          trl_d     = 1'b0;
          busy_d    = 1'b1;
          tx_req_d  = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_ack) begin
          tx_req_d = 1'b0;
          if (!trl_q) crc_d = crc_next;
          state_d  = ST_ACKLO;
        end
      end
      ST_ACKLO: begin
        if (!tx_ack) begin
          if (!pl_last) begin
            state_d = ST_FETCH;
          end else if (crc_en_q && !trl_q) begin
            tx_data_d = crc_q;
            trl_d     = 1'b1;
            tx_req_d  = 1'b1;
            state_d   = ST_REQ;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FETCH: begin
        if (pl_valid) begin
          tx_data_d = pl_data;
          cnt_d     = cnt_q + CNT_ONE;
          tx_req_d  = 1'b1;
          state_d   = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      crc_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      tx_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_en_q  <= 1'b0;
      trl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tx_req_q  <= tx_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      crc_en_q  <= crc_en_d;
      trl_q     <= trl_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign pl_ready  = (state_q == ST_FETCH);
  assign tx_data   = tx_data_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_yas_packet_tx.sv
// Scoreboard bench for yas_packet_tx: commands push expected wire bytes from a
// packet-level model; a monitor pops and compares each byte as req rises.
module tb_yas_packet_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len_m1 = '0;
  logic       cmd_crc_en = 1'b0;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ack;
  logic       busy;
  logic       done;
  logic       resp_ack = 1'b0;
  logic       spur_ack = 1'b0;

  assign tx_ack = resp_ack | spur_ack;

  always #5 clk = ~clk;

  yas_packet_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len_m1 (cmd_len_m1),
    .cmd_crc_en (cmd_crc_en),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .tx_ack     (tx_ack),
    .busy       (busy),
    .done       (done)
  );

  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];
  logic [7:0] obs_q[$];
  int total = 0;
  int bad = 0;
  int ack_hi_dly = 0;
  int ack_lo_dly = 0;
  bit gaps = 1'b0;
  int ack_count = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // CRC-8 as polynomial division of the message bit stream, MSB first.
  function automatic logic [7:0] crc_model(input logic [7:0] msg[$]);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[i][b];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return r;
  endfunction

  // mode 0: random payload, 1: ramp 0,1,2..., 2: every byte 0xA5
  task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len,
                          input logic crc, input int mode);
    logic [7:0] pkt[$];
    logic [7:0] pl[$];
    int waited;
    for (int i = 0; i <= int'(len); i++)
      pl.push_back(mode == 1 ? 8'(i) : (mode == 2 ? 8'hA5 : 8'($urandom)));
    @(negedge clk);
    cmd_addr = addr; cmd_len_m1 = len; cmd_crc_en = crc; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_accept_in_time", 32'(waited < 5000), 1);
    pkt.push_back(8'(int'(len) * 4 + int'(addr)));
    foreach (pl[i]) pkt.push_back(pl[i]);
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
    if (crc) exp_q.push_back(crc_model(pkt));
    foreach (pl[i]) pl_q.push_back(pl[i]);
    @(posedge clk);
    #1;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic cmd_drop();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = 2'($urandom); cmd_len_m1 = 6'($urandom); cmd_crc_en = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("packet_complete_in_time", 32'(n < 20000), 1);
    @(negedge clk);
  endtask

  // Payload source: offers the head of pl_q, with optional random gaps.
  initial begin
    bit fire;
    fire = 1'b0;
    pl_valid = 1'b0;
    pl_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pl_valid = 1'b0;
        fire = 1'b0;
      end else begin
        if (fire && pl_q.size() > 0) void'(pl_q.pop_front());
        if (pl_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          pl_valid = 1'b1;
          pl_data = pl_q[0];
        end else begin
          pl_valid = 1'b0;
        end
        fire = pl_valid && pl_ready;
      end
    end
  end

  // Ack responder with programmable high/low latencies.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_ack = 1'b0;
        cnt = 0;
      end else if (!resp_ack) begin
        if (tx_req) begin
          if (cnt >= ack_hi_dly) begin
            resp_ack = 1'b1; cnt = 0; ack_count++;
          end else cnt++;
        end else cnt = 0;
      end else if (!tx_req) begin
        if (cnt >= ack_lo_dly) begin
          resp_ack = 1'b0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitor: compares each byte at req rise and its stability through the handshake.
  initial begin
    bit prev_req, prev_done, holding, stable_ok;
    logic [7:0] hold_byte;
    prev_req = 0; prev_done = 0; holding = 0; stable_ok = 1; hold_byte = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_req = 0; prev_done = 0; holding = 0;
      end else begin
        check("cmd_ready_is_not_busy", cmd_ready, !busy);
        if (holding && !tx_req && !tx_ack) begin
          check("tx_data_stable", stable_ok, 1);
          holding = 0;
        end
        if (tx_req && !prev_req) begin
          if (holding) begin
            check("tx_data_stable", stable_ok, 1);
            holding = 0;
          end
          check("req_rise_with_ack_low", tx_ack, 0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte: got 0x%0h, wanted no byte", tx_data);
          end else begin
            check("tx_byte", tx_data, exp_q.pop_front());
          end
          obs_q.push_back(tx_data);
          holding = 1; hold_byte = tx_data; stable_ok = 1;
        end else if (holding && (tx_req || tx_ack) && tx_data !== hold_byte) begin
          stable_ok = 0;
        end
        if (done) begin
          check("busy_low_with_done", busy, 0);
          check("done_single_cycle", prev_done, 0);
          check("all_bytes_sent_at_done", exp_q.size(), 0);
          done_cnt++;
        end
        prev_done = done;
        prev_req = tx_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, wanted test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit[3];
    int base, target, n;
    lit = '{8'h01, 8'hA5, 8'h67};

    // Reset values
    #12;
    check("rst_tx_req", tx_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tx_data", tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spurious ack in IDLE
    repeat (4) begin
      @(negedge clk); spur_ack = 1'b1;
      @(negedge clk); spur_ack = 1'b0;
    end
    @(negedge clk);
    check("spur_tx_req", tx_req, 0);
    check("spur_busy", busy, 0);
    check("spur_done", done, 0);
    check("spur_pl_ready", pl_ready, 0);
    check("spur_cmd_ready", cmd_ready, 1);
    check("spur_tx_data", tx_data, 0);

    // Basic packet with CRC
    obs_q.delete();
    base = done_cnt;
    send_cmd(2'd1, 6'd0, 1'b1, 2);
    cmd_drop();
    wait_idle();
    check("basic_byte_count", obs_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < obs_q.size()) check("basic_literal_byte", obs_q[i], lit[i]);
    check("basic_done_once", done_cnt - base, 1);

    // Max length, no CRC
    obs_q.delete();
    send_cmd(2'd3, 6'd63, 1'b0, 1);
    cmd_drop();
    wait_idle();
    check("max_byte_count", obs_q.size(), 65);
    if (obs_q.size() == 65) begin
      check("max_header", obs_q[0], 8'hFF);
      check("max_last_payload", obs_q[64], 8'h3F);
    end

    // Slow responder with payload gaps
    ack_hi_dly = 5; ack_lo_dly = 3; gaps = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send_cmd(2'($urandom), 6'($urandom_range(0, 9)), 1'b1, 0);
      cmd_drop();
      wait_idle();
    end

    // Back-to-back commands with cmd_valid held
    ack_hi_dly = 1; ack_lo_dly = 1;
    base = done_cnt;
    send_cmd(2'd2, 6'd3, 1'b1, 0);
    send_cmd(2'd0, 6'd2, 1'b0, 0);
    check("second_accept_after_first_done", done_cnt - base, 1);
    cmd_drop();
    wait_idle();
    check("back_to_back_done_count", done_cnt - base, 2);

    // Randomized packets
    for (int k = 0; k < 8; k++) begin
      ack_hi_dly = $urandom_range(0, 2);
      ack_lo_dly = $urandom_range(0, 2);
      send_cmd(2'($urandom), 6'($urandom_range(0, 15)), 1'($urandom), 0);
      cmd_drop();
      wait_idle();
    end

    // Reset after the second payload ack
    ack_hi_dly = 0; ack_lo_dly = 0;
    target = ack_count + 3;
    send_cmd(2'd1, 6'd5, 1'b1, 0);
    cmd_drop();
    n = 0;
    while (ack_count < target && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reach_second_payload_ack", 32'(n < 5000), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_req", tx_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_pl_ready", pl_ready, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    exp_q.delete(); pl_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    send_cmd(2'd2, 6'd4, 1'b1, 0);
    cmd_drop();
    wait_idle();

    check("scoreboard_empty", exp_q.size(), 0);
    check("payload_consumed", pl_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
